sram_controller: RTL
====================

# sram_controller

Data-memory back end for the MIPS pipeline: sits directly downstream of the MEM stage and replaces its internal memory array with the board's external 16-bit asynchronous SRAM. It converts each 32-bit MEM-stage load/store into two 16-bit SRAM accesses with programmable wait states. While a transaction is in flight it drops `ready`, which the top level uses as a pipeline-wide freeze.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address of data-memory word 0; subtracted from `address` before mapping.
- `ACCESS_CYCLES`, 2: clock cycles each 16-bit half-access is held on the SRAM bus (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_en` input 1: store request from EXE/MEM register.
- `rd_en` input 1: load request from EXE/MEM register.
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store value.
- `read_data` output 32: load result, registered.
- `ready` output 1: 1 when no request is pending or the current request completes this cycle.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output 18: SRAM halfword address.
- `SRAM_WE_N` output 1: write enable, active low.
- `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` output 1 each: tied to 0.

## Operation
- States: IDLE, LOW, HIGH, DONE. `cnt` is an internal wait counter, width ≥ clog2(`ACCESS_CYCLES`)+1.
- Address map: `w = address - BASE_ADDR`, modulo 2^32. Word index is `w[18:2]`. Bits `w[1:0]` are ignored; accesses are word-aligned only. Out-of-range addresses wrap onto the 128K-word space; no error is raised.
- IDLE: if `wr_en | rd_en`, capture `address`, `write_data` and op into internal registers, clear `cnt`, go to LOW. If both enables are set, the op is a write.
- LOW: `SRAM_ADDR = {w[18:2], 1'b0}`. Increment `cnt`. When `cnt == ACCESS_CYCLES-1`:
  - on a read, latch `SRAM_DQ` into `read_data[15:0]`;
  - clear `cnt` and go to HIGH.
- HIGH: same as LOW, but with `SRAM_ADDR = {w[18:2], 1'b1}` and `read_data[31:16]`. Exit goes to DONE.
- DONE: `ready = 1` for exactly one cycle, then go to IDLE unconditionally. A request present in DONE is treated as already served and is not restarted.
- On a write, `SRAM_WE_N = 0` and `SRAM_DQ` is driven with the captured `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH. In all other states and on reads, `SRAM_WE_N = 1` and `SRAM_DQ` is high-Z.
- Decoding of `SRAM_ADDR`, `SRAM_WE_N` and the DQ output enable uses registered state and captured values only, never live pipeline inputs.
- `ready = (state == DONE) | (state == IDLE & ~wr_en & ~rd_en)`.
- `read_data` changes only on a read's latch cycles and is otherwise held. Writes do not alter it.

## Timing
- Reset asserted, at any time including mid-transaction:
  - state IDLE, `cnt = 0`, `read_data = 0`, captured registers 0;
  - `SRAM_WE_N = 1`, DQ high-Z, `SRAM_ADDR = 0`, all taking effect immediately.
- While reset is held with no request, `ready = 1`. An aborted write may leave that SRAM halfword corrupted; this is acceptable.
- Per-request latency, measured from the IDLE cycle in which the request is seen (cycle 0):
  - `ready = 0` in cycles 0 through 2·`ACCESS_CYCLES`;
  - `ready = 1` in cycle 2·`ACCESS_CYCLES`+1 (DONE).
  - With defaults, 5 freeze cycles, then release in cycle 5.
- `read_data` is valid in DONE and stays valid until the next read's latch.
- The low half is sampled at the rising edge ending the last LOW cycle; the high half at the edge ending the last HIGH cycle.
- Back-to-back requests: a new request first seen in the IDLE cycle after DONE starts a fresh transaction. Minimum period is 2·`ACCESS_CYCLES`+2 cycles per access.
- Inputs may change during LOW/HIGH/DONE without effect, since captured copies are used.
- `ACCESS_CYCLES = 1` is legal: LOW and HIGH last one cycle each.

## Test plan
- Reset: drive `rst = 0` mid-LOW of a write. Required: `SRAM_WE_N` goes to 1 and DQ to Z without waiting for a clock edge, `read_data = 0` and state IDLE. After release with no request, `ready = 1`.
- Store then load, defaults: write `address = 1028`, `write_data = 0xDEADBEEF`. Required:
  - SRAM model sees halfword addr 2 ← 0xBEEF, then addr 3 ← 0xDEAD;
  - `ready` is low for 5 cycles.
  - Then read 1028. Required: `read_data = 0xDEADBEEF` in the DONE cycle.
- Freeze timing: assert `rd_en` continuously for three reads at 1024, 1032, 1036. Required: `ready` pattern of five 0s then one 1, repeated three times, with one IDLE cycle between transactions. Each result matches the model.
- Input change during access: start a write to 1024 (value 0x11112222), then switch `address` to 2048 and `write_data` to 0 in cycle 1. Required: SRAM addresses 0/1 receive 0x2222/0x1111; addresses 512/513 are untouched.
- Corner cases:
  - Both `rd_en` and `wr_en` set to `address` 1024 + 4·131071 with value 0x0F0F0F0F: write occurs at halfwords 0x3FFFE/0x3FFFF, and `read_data` is unchanged.
  - `address = 1020`: wraps to word 131071.
- `ACCESS_CYCLES = 1`, read of 1040: required `ready` low for 3 cycles, then high. DQ is never driven by the controller.

Source files
------------

// File: rtl/sram_controller.sv
// MEM-stage data memory back end: splits each 32-bit load/store into two
// 16-bit accesses on an external asynchronous SRAM with programmable wait states.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [16:0]       word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic [31:0]       read_data_q, read_data_d;

    logic [31:0]       offset;
    logic              request;
    logic              last_beat;
    logic              dq_oe;
    logic [15:0]       dq_out;
    logic              unused_offset_bits;

    assign offset             = address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign request            = wr_en | rd_en;
    assign last_beat          = (cnt_q == CNT_LAST);

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (request)   state_d = LOW;
            LOW:     if (last_beat) state_d = HIGH;
            HIGH:    if (last_beat) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Capture on request; wait-count each half; latch read halves on its last cycle.
    always_comb begin
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    word_d     = offset[18:2];
                    wdata_d    = write_data;
                    is_write_d = wr_en;
                    cnt_d      = '0;
                end
            end
            LOW: begin
                cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                if (last_beat && !is_write_q) read_data_d[15:0] = SRAM_DQ;
            end
            HIGH: begin
                cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                if (last_beat && !is_write_q) read_data_d[31:16] = SRAM_DQ;
            end
            default: ;
        endcase
    end

    // Bus outputs come from registered state only, never from live pipeline inputs.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        ready     = 1'b0;
        case (state_q)
            IDLE: ready = ~request;
            LOW: begin
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = ~is_write_q;
                dq_oe     = is_write_q;
                dq_out    = wdata_q[15:0];
            end
            HIGH: begin
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = ~is_write_q;
                dq_oe     = is_write_q;
                dq_out    = wdata_q[31:16];
            end
            DONE: ready = 1'b1;
            default: ;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign read_data = read_data_q;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
